// File: rtl/cache_refill_arbiter.sv
// Two-requester line refill/writeback arbiter serialising cache lines into single-word bus beats.
// Optional macro ARB_FIXED_PRIO_EN: requester 1 wins ties instead of round-robin.
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*LINE_WIDTH-1:0] req_wline,
    output logic [1:0]              resp_valid,
    output logic [LINE_WIDTH-1:0]   resp_line,
    output logic                    busy,
    output logic                    grant_id,
    output logic                    bus_valid,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int DATA_PER_LINE = LINE_WIDTH / DATA_WIDTH;
    localparam int CNT_W         = $clog2(DATA_PER_LINE);
    localparam int OFF_W         = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(DATA_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    we_r;
    logic [LINE_WIDTH-1:0]   line_buf_r;
`ifdef ARB_FIXED_PRIO_EN
`else
    logic                    rr_r;
`endif

    logic                    win_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [ADDR_WIDTH-1:0]   base_s;
    logic [LINE_WIDTH-1:0]   sel_wline_s;
    logic [LINE_WIDTH-1:0]   merged_s;
    logic [CNT_W-1:0]        nxt_cnt_s;

    // Arbitration: a lone requester wins; ties go to rr (or requester 1 when fixed priority)
    always_comb begin
        win_s = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            win_s = 1'b1;
`else
            win_s = rr_r;
`endif
        end else begin
            win_s = req_valid[1];
        end
    end

    // Winner's request fields and line-aligned base address
    always_comb begin
        sel_addr_s  = req_addr[win_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wline_s = req_wline[win_s*LINE_WIDTH +: LINE_WIDTH];
        base_s      = (sel_addr_s >> OFF_W) << OFF_W;
    end

    // Line buffer with the current beat's read data merged in (writes keep the latched line)
    always_comb begin
        merged_s  = line_buf_r;
        nxt_cnt_s = cnt_r + CNT_W'(1);
        if (!we_r) begin
            merged_s[cnt_r*DATA_WIDTH +: DATA_WIDTH] = bus_rdata;
        end else begin
            merged_s = line_buf_r;
        end
    end

    // Burst controller: latch winner, issue beats until the last ack, pulse the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            we_r       <= 1'b0;
            line_buf_r <= '0;
            resp_valid <= 2'b00;
            resp_line  <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
`ifdef ARB_FIXED_PRIO_EN
`else
            rr_r       <= 1'b0;
`endif
        end else begin
            resp_valid <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state_r   <= ST_BURST;
                        grant_id  <= win_s;
                        we_r      <= req_we[win_s];
                        cnt_r     <= '0;
                        busy      <= 1'b1;
                        bus_valid <= 1'b1;
                        bus_we    <= req_we[win_s];
                        bus_addr  <= base_s;
                        if (req_we[win_s]) begin
                            line_buf_r <= sel_wline_s;
                            bus_wdata  <= sel_wline_s[DATA_WIDTH-1:0];
                        end else begin
                            bus_wdata  <= '0;
                        end
                    end
                end
                ST_BURST: begin
                    if (bus_ack) begin
                        line_buf_r <= merged_s;
                        if (cnt_r == LAST_CNT) begin
                            state_r              <= ST_RESP;
                            bus_valid            <= 1'b0;
                            bus_we               <= 1'b0;
                            bus_addr             <= '0;
                            bus_wdata            <= '0;
                            resp_line            <= merged_s;
                            resp_valid[grant_id] <= 1'b1;
                        end else begin
                            cnt_r    <= nxt_cnt_s;
                            bus_addr <= bus_addr + BEAT_STRIDE;
                            if (we_r) begin
                                bus_wdata <= line_buf_r[nxt_cnt_s*DATA_WIDTH +: DATA_WIDTH];
                            end else begin
                                bus_wdata <= '0;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
                    rr_r    <= ~grant_id;
`endif
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    busy      <= 1'b0;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench for cache_refill_arbiter: directed requests, bus responder model, decoupled monitor.
`timescale 1ns/1ps
module tb_cache_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 256;
    localparam int N  = LW / DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_we = 2'b00;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*LW-1:0]   req_wline = '0;
    logic [1:0]        resp_valid;
    logic [LW-1:0]     resp_line;
    logic              busy, grant_id, bus_valid, bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ack = 1'b0;
    logic [DW-1:0]     bus_rdata = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stall_n = 0;
    int beats_seen = 0;

    typedef struct packed { logic id; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } beat_t;
    typedef struct packed { logic id; logic [LW-1:0] line; int at; } resp_t;
    beat_t beat_q[$];
    resp_t resp_q[$];

    cache_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wline(req_wline), .resp_valid(resp_valid), .resp_line(resp_line), .busy(busy),
        .grant_id(grant_id), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [LW-1:0] mk_wline(input logic [7:0] tag);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < N; k++) l[k*DW +: DW] = {8'hC0, tag, 8'h00, 8'(k)};
        return l;
    endfunction

    task automatic expect_line(input logic id, input logic we, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wline, input int at);
        beat_t b;
        resp_t r;
        logic [AW-1:0] base;
        base = addr & 32'hFFFF_FFE0;
        r.line = '0;
        for (int k = 0; k < N; k++) begin
            b.id    = id;
            b.we    = we;
            b.addr  = base + 32'(4 * k);
            b.wdata = we ? wline[k*DW +: DW] : 32'h0;
            r.line[k*DW +: DW] = we ? wline[k*DW +: DW] : mem_word(b.addr);
            beat_q.push_back(b);
        end
        r.id = id;
        r.at = at;
        resp_q.push_back(r);
    endtask

    task automatic issue(input logic id, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wline);
        req_we[id] = we;
        req_addr[id*AW +: AW] = addr;
        req_wline[id*LW +: LW] = wline;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_resp(input logic id, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid[id]) got = 1'b1;
        end
        req_valid[id] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no resp_valid[%0d] within 300 cycles", name, id);
        end
    endtask

    // Bus slave: acks after stall_n wait cycles, returns mem_word(addr)
    initial begin : responder
        int wt;
        wt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus_valid) begin
                bus_ack = 1'b0;
                wt = 0;
            end else begin
                bus_rdata = mem_word(bus_addr);
                if (wt >= stall_n) begin
                    bus_ack = 1'b1;
                    wt = 0;
                end else begin
                    bus_ack = 1'b0;
                    wt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever a beat completes or a response pulses
    initial begin : monitor
        bit prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_wdata;
        beat_t b;
        resp_t r;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus_valid && prev_stall) begin
                    chk("hold_addr", LW'(bus_addr), LW'(prev_addr));
                    chk("hold_wdata", LW'(bus_wdata), LW'(prev_wdata));
                end
                prev_stall = bus_valid && !bus_ack;
                prev_addr  = bus_addr;
                prev_wdata = bus_wdata;
                if (bus_valid && bus_ack) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL beat_unexpected: got addr %h expected no beat", bus_addr);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_addr", LW'(bus_addr), LW'(b.addr));
                        chk("beat_we", LW'(bus_we), LW'(b.we));
                        chk("beat_grant", LW'(grant_id), LW'(b.id));
                        if (b.we) chk("beat_wdata", LW'(bus_wdata), LW'(b.wdata));
                        beats_seen++;
                    end
                end
                if (resp_valid != 2'b00) begin
                    if (resp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL resp_unexpected: got resp_valid %b expected 00", resp_valid);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_valid", LW'(resp_valid), LW'(2'b01 << r.id));
                        chk("resp_line", resp_line, r.line);
                        if (r.at >= 0) chk("resp_cycle", LW'(cyc), LW'(r.at));
                    end
                end
            end
        end
    end

    initial begin : stim
        int start;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_bus_valid", LW'(bus_valid), LW'(1'b0));
        chk("rst_busy", LW'(busy), LW'(1'b0));
        chk("rst_resp_valid", LW'(resp_valid), LW'(2'b00));
        chk("rst_grant", LW'(grant_id), LW'(1'b0));
        chk("rst_bus_addr", LW'(bus_addr), LW'(32'h0));
        chk("rst_resp_line", resp_line, '0);

        // Both requesters contend straight out of reset
        @(posedge clk); #1;
`ifdef ARB_FIXED_PRIO_EN
        expect_line(1'b1, 1'b1, 32'h0000_4400, mk_wline(8'h11), -1);
        expect_line(1'b0, 1'b0, 32'h0000_5000, '0, -1);
`else
        expect_line(1'b0, 1'b0, 32'h0000_5000, '0, -1);
        expect_line(1'b1, 1'b1, 32'h0000_4400, mk_wline(8'h11), -1);
`endif
        expect_line(1'b0, 1'b0, 32'h0000_6020, '0, -1);
        fork
            begin
                issue(1'b0, 1'b0, 32'h0000_5000, '0);
                wait_resp(1'b0, "rr_first0");
                @(posedge clk); #1;
                issue(1'b0, 1'b0, 32'h0000_6020, '0);
                wait_resp(1'b0, "rr_second0");
            end
            begin
                issue(1'b1, 1'b1, 32'h0000_4400, mk_wline(8'h11));
                wait_resp(1'b1, "rr_first1");
            end
        join

        // Single refill, request fields disturbed mid-burst
        @(posedge clk); #1;
        expect_line(1'b0, 1'b0, 32'h8000_0014, '0, cyc + 9);
        issue(1'b0, 1'b0, 32'h8000_0014, '0);
        repeat (3) @(posedge clk);
        #1;
        req_addr[0 +: AW] = 32'hDEAD_BEEF;
        req_we[0] = 1'b1;
        wait_resp(1'b0, "refill0");

        // Writeback from requester 1
        @(posedge clk); #1;
        expect_line(1'b1, 1'b1, 32'h0000_1040, mk_wline(8'h22), cyc + 9);
        issue(1'b1, 1'b1, 32'h0000_1040, mk_wline(8'h22));
        wait_resp(1'b1, "writeback1");

        // Three-cycle stall on every beat, as a writeback so wdata holding is exercised
        stall_n = 3;
        @(posedge clk); #1;
        expect_line(1'b0, 1'b1, 32'h0000_3000, mk_wline(8'h33), cyc + 33);
        issue(1'b0, 1'b1, 32'h0000_3000, mk_wline(8'h33));
        wait_resp(1'b0, "stall0");
        stall_n = 0;

        // Top-of-address-space line
        @(posedge clk); #1;
        expect_line(1'b1, 1'b0, 32'hFFFF_FFF0, '0, cyc + 9);
        issue(1'b1, 1'b0, 32'hFFFF_FFF0, '0);
        wait_resp(1'b1, "wrap1");

        // Reset after three beats, then restart from the line base
        @(posedge clk); #1;
        expect_line(1'b0, 1'b0, 32'h0000_2008, '0, -1);
        issue(1'b0, 1'b0, 32'h0000_2008, '0);
        start = beats_seen;
        for (int i = 0; i < 100 && beats_seen < start + 3; i++) @(posedge clk);
        chk("rst_mid_beats", LW'(beats_seen - start), LW'(3));
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_bus_valid", LW'(bus_valid), LW'(1'b0));
        chk("mid_rst_busy", LW'(busy), LW'(1'b0));
        chk("mid_rst_resp_valid", LW'(resp_valid), LW'(2'b00));
        chk("mid_rst_bus_addr", LW'(bus_addr), LW'(32'h0));
        req_valid = 2'b00;
        beat_q.delete();
        resp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        expect_line(1'b0, 1'b0, 32'h0000_2008, '0, cyc + 9);
        issue(1'b0, 1'b0, 32'h0000_2008, '0);
        wait_resp(1'b0, "restart0");

        repeat (5) @(posedge clk);
        #1;
        chk("beat_q_drained", LW'(beat_q.size()), LW'(0));
        chk("resp_q_drained", LW'(resp_q.size()), LW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
